// File: rtl/usr_pkg.sv
// -----------------------------------------------------------------------------
// usr_pkg
// Shared definitions for the universal shift register and its tx sequencer:
//   - register mode encodings (driven on the register's mode inputs)
//   - sequencer state encoding
//   - counter width helper for the per-bit timer
// No ports.
// -----------------------------------------------------------------------------
package usr_pkg;

   typedef enum logic [1:0] {
      NO_CHANGE     = 2'b00,
      SHIFT_RIGHT   = 2'b01,
      SHIFT_LEFT    = 2'b10,
      LOAD_PARALLEL = 2'b11
   } usr_mode_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      LOAD = 2'b01,
      BIT  = 2'b10
   } seq_state_e;

   localparam logic [2:0] LAST_BIT_IDX = 3'd7;

   // Width of a counter spanning 0..n-1, never narrower than one bit.
   function automatic int cyc_width(input int n);
      if (n <= 2) begin
         return 1;
      end
      return $clog2(n);
   endfunction

endpackage

// File: rtl/usr_bit_timer.sv
// -----------------------------------------------------------------------------
// usr_bit_timer
// Per-bit hold timer. Down-counter reloaded with BIT_CYCLES-1; the terminal
// count (zero) marks the last cycle a bit is presented.
//   Clk_In            clock
//   Reset_In          async active-high reset (counter returns to reload value)
//   Clear_In          reload the counter; takes priority over counting
//   Count_En_In       decrement while non-zero
//   Terminal_Out      counter is at zero: last cycle of the current bit
//   Near_Terminal_Out counter is at one: next cycle is the last of the bit
// -----------------------------------------------------------------------------
module usr_bit_timer
   import usr_pkg::*;
#(
   parameter int BIT_CYCLES = 1
) (
   input  logic Clk_In,
   input  logic Reset_In,
   input  logic Clear_In,
   input  logic Count_En_In,
   output logic Terminal_Out,
   output logic Near_Terminal_Out
);

   localparam int            W      = cyc_width(BIT_CYCLES);
   localparam logic [W-1:0]  RELOAD = W'(BIT_CYCLES - 1);
   localparam logic [W-1:0]  ONE    = W'(1);

   logic [W-1:0] cnt_q;

   always_ff @(posedge Clk_In or posedge Reset_In) begin
      if (Reset_In) begin
         cnt_q <= RELOAD;
      end else if (Clear_In) begin
         cnt_q <= RELOAD;
      end else if (Count_En_In && (cnt_q != '0)) begin
         cnt_q <= cnt_q - ONE;
      end
   end

   assign Terminal_Out      = (cnt_q == '0);
   // With BIT_CYCLES==1 the counter is pinned at zero, so this never fires;
   // the sequencer handles that case itself.
   assign Near_Terminal_Out = (cnt_q == ONE);

endmodule

// File: rtl/usr_tx_sequencer.sv
// -----------------------------------------------------------------------------
// usr_tx_sequencer
// Drives an 8-bit universal shift register so that its serial output presents
// an accepted byte LSB first: one parallel load, then seven right-shifts, each
// bit held for BIT_CYCLES clocks.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no frame; Ready_Out high unless aborting
//   LOAD  | one cycle, Mode_Out = 11, register loads latched byte
//   BIT   | bit bit_idx presented; timer counts hold cycles of the bit
//
// Ports:
//   Clk_In, Reset_In          clock, async active-high reset
//   Data_In, Valid_In         byte offered for transmission
//   Ready_Out                 byte accepted at next posedge when Valid_In
//   Abort_In                  drop the current frame, return to IDLE
//   Mode_Out                  register mode (never 10)
//   Parallel_Data_Out         latched byte for the register's parallel input
//   Serial_Fill_Out           constant FILL_BIT for the vacated MSB
//   Bit_Valid_Out             register serial output holds Bit_Index_Out at
//                             the posedge that ends this cycle
//   Bit_Index_Out             index of the bit currently presented
//   Last_Bit_Out              final cycle of bit 7
// -----------------------------------------------------------------------------
module usr_tx_sequencer
   import usr_pkg::*;
#(
   parameter int   BIT_CYCLES = 1,
   parameter logic FILL_BIT   = 1'b0
) (
   input  logic       Clk_In,
   input  logic       Reset_In,
   input  logic [7:0] Data_In,
   input  logic       Valid_In,
   output logic       Ready_Out,
   input  logic       Abort_In,
   output logic [1:0] Mode_Out,
   output logic [7:0] Parallel_Data_Out,
   output logic       Serial_Fill_Out,
   output logic       Bit_Valid_Out,
   output logic [2:0] Bit_Index_Out,
   output logic       Last_Bit_Out
);

   localparam logic ONE_CYCLE = (BIT_CYCLES == 1);

   seq_state_e state_q;
   usr_mode_e  mode_q;
   logic [2:0] bit_idx_q;
   logic [7:0] byte_q;
   logic       last_q;

   logic       tc;
   logic       near_tc;
   logic       timer_clr;
   logic       timer_en;
   logic       accept;

   // The timer is reloaded whenever a new bit starts (including the LOAD
   // cycle before bit 0) and on abort, so every bit begins with a full hold.
   assign timer_clr = (state_q != BIT) || tc || Abort_In;
   assign timer_en  = (state_q == BIT);

   usr_bit_timer #(
      .BIT_CYCLES (BIT_CYCLES)
   ) u_bit_timer (
      .Clk_In            (Clk_In),
      .Reset_In          (Reset_In),
      .Clear_In          (timer_clr),
      .Count_En_In       (timer_en),
      .Terminal_Out      (tc),
      .Near_Terminal_Out (near_tc)
   );

   // last_q mirrors "BIT and bit 7 and final hold cycle" from registered state,
   // which lets the frame end and the next acceptance share one edge.
   assign Ready_Out = ((state_q == IDLE) || last_q) && !Abort_In;
   assign accept    = Valid_In && Ready_Out;

   // mode_q, bit_idx_q and last_q are computed one cycle ahead so the
   // register-facing outputs come straight from flops.
   always_ff @(posedge Clk_In or posedge Reset_In) begin
      if (Reset_In) begin
         state_q   <= IDLE;
         mode_q    <= NO_CHANGE;
         bit_idx_q <= '0;
         byte_q    <= '0;
         last_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               mode_q    <= NO_CHANGE;
               bit_idx_q <= '0;
               last_q    <= 1'b0;
               if (accept) begin
                  state_q <= LOAD;
                  byte_q  <= Data_In;
                  mode_q  <= LOAD_PARALLEL;
               end
            end

            LOAD: begin
               mode_q    <= NO_CHANGE;
               bit_idx_q <= '0;
               last_q    <= 1'b0;
               state_q   <= Abort_In ? IDLE : BIT;
            end

            BIT: begin
               if (Abort_In) begin
                  state_q   <= IDLE;
                  mode_q    <= NO_CHANGE;
                  bit_idx_q <= '0;
                  last_q    <= 1'b0;
               end else if (!tc) begin
                  mode_q <= NO_CHANGE;
                  last_q <= (bit_idx_q == LAST_BIT_IDX) && near_tc;
               end else if (bit_idx_q != LAST_BIT_IDX) begin
                  // First cycle of the next bit: shift it into position.
                  bit_idx_q <= bit_idx_q + 3'd1;
                  mode_q    <= SHIFT_RIGHT;
                  last_q    <= ONE_CYCLE && (bit_idx_q == 3'd6);
               end else begin
                  bit_idx_q <= '0;
                  last_q    <= 1'b0;
                  if (accept) begin
                     state_q <= LOAD;
                     byte_q  <= Data_In;
                     mode_q  <= LOAD_PARALLEL;
                  end else begin
                     state_q <= IDLE;
                     mode_q  <= NO_CHANGE;
                  end
               end
            end

            default: begin
               state_q   <= IDLE;
               mode_q    <= NO_CHANGE;
               bit_idx_q <= '0;
               last_q    <= 1'b0;
            end
         endcase
      end
   end

   // Abort suppresses the pending load/shift in the same cycle so the
   // register keeps whatever it held.
   assign Mode_Out          = (Abort_In && (state_q != IDLE)) ? NO_CHANGE : mode_q;
   assign Parallel_Data_Out = byte_q;
   assign Serial_Fill_Out   = FILL_BIT;
   assign Bit_Valid_Out     = (state_q == BIT);
   assign Bit_Index_Out     = bit_idx_q;
   assign Last_Bit_Out      = last_q;

endmodule

// File: tb/tb_usr_tx_sequencer.sv
// -----------------------------------------------------------------------------
// tb_usr_tx_sequencer
// Two sequencer instances (BIT_CYCLES 1 and 3, different fill bits), each with
// a model of the downstream shift register and a frame-level reference model.
// Accepted bytes are queued at the handshake edge; a negedge monitor pops them
// when the load is expected and checks every output cycle by cycle.
// -----------------------------------------------------------------------------
module tb_usr_tx_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       valid [2];
   logic [7:0] data  [2];
   logic       abort [2];
   logic       ready [2];
   logic [1:0] mode  [2];
   logic [7:0] par   [2];
   logic       fill  [2];
   logic       bv    [2];
   logic [2:0] idx   [2];
   logic       last  [2];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   function automatic int bc_of(input int l);
      return (l == 0) ? 1 : 3;
   endfunction

   task automatic chk(input int l, input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL lane%0d %s: got %0d, expected %0d at %0t", l, name, act, exp, $time);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : lane
      localparam int   BC = (g == 0) ? 1 : 3;
      localparam logic FB = (g == 0) ? 1'b0 : 1'b1;

      logic [7:0] exp_q [$];
      logic [7:0] sreg = 8'h00;
      logic [7:0] cur_byte = 8'h00;
      bit         load_cyc = 1'b0;
      bit         active = 1'b0;
      bit         exp_rdy = 1'b0;
      int         pos = 0;

      usr_tx_sequencer #(
         .BIT_CYCLES (BC),
         .FILL_BIT   (FB)
      ) u_dut (
         .Clk_In            (clk),
         .Reset_In          (rst),
         .Data_In           (data[g]),
         .Valid_In          (valid[g]),
         .Ready_Out         (ready[g]),
         .Abort_In          (abort[g]),
         .Mode_Out          (mode[g]),
         .Parallel_Data_Out (par[g]),
         .Serial_Fill_Out   (fill[g]),
         .Bit_Valid_Out     (bv[g]),
         .Bit_Index_Out     (idx[g]),
         .Last_Bit_Out      (last[g])
      );

      // Scoreboard push: a byte is accepted at the posedge when the model
      // says the sequencer is ready and Valid_In is high.
      always @(posedge clk) begin
         if (!rst && valid[g] && exp_rdy) exp_q.push_back(data[g]);
      end

      always @(negedge clk) begin : mon
         bit         ab;
         bit         e_bv;
         bit         e_last;
         bit         e_rdy;
         int         e_idx;
         logic [1:0] e_mode;
         if (rst) begin
            chk(g, "rst_mode",   mode[g], 0);
            chk(g, "rst_ready",  ready[g], 1);
            chk(g, "rst_bvalid", bv[g], 0);
            chk(g, "rst_index",  idx[g], 0);
            chk(g, "rst_last",   last[g], 0);
            chk(g, "rst_pdata",  par[g], 0);
            exp_q.delete();
            load_cyc = 1'b0;
            active   = 1'b0;
            exp_rdy  = 1'b0;
         end else begin
            ab     = abort[g];
            e_bv   = 1'b0;
            e_last = 1'b0;
            e_idx  = 0;
            e_mode = 2'b00;
            if (load_cyc) begin
               e_mode = ab ? 2'b00 : 2'b11;
               chk(g, "load_queue_nonempty", (exp_q.size() > 0) ? 1 : 0, 1);
               if (exp_q.size() > 0) cur_byte = exp_q.pop_front();
               chk(g, "load_pdata", par[g], cur_byte);
            end else if (active) begin
               e_bv   = 1'b1;
               e_idx  = pos / BC;
               e_last = (pos == 8 * BC - 1);
               if (!ab && (pos % BC == 0) && (e_idx != 0)) e_mode = 2'b01;
            end
            e_rdy = !ab && ((!load_cyc && !active) || e_last);

            chk(g, "mode",   mode[g], e_mode);
            chk(g, "bvalid", bv[g], e_bv);
            chk(g, "last",   last[g], e_last);
            chk(g, "ready",  ready[g], e_rdy);
            chk(g, "fill",   fill[g], FB);

            // Downstream register acts on the sequencer's mode at this negedge.
            case (mode[g])
               2'b11:   sreg = par[g];
               2'b01:   sreg = {fill[g], sreg[7:1]};
               2'b10:   sreg = {sreg[6:0], 1'b0};
               default: sreg = sreg;
            endcase

            if (e_bv) begin
               chk(g, "bit_index", idx[g], e_idx);
               if (!ab) chk(g, "serial_bit", sreg[0], cur_byte[e_idx]);
            end

            if (ab) begin
               load_cyc = 1'b0;
               active   = 1'b0;
            end else if (load_cyc) begin
               load_cyc = 1'b0;
               active   = 1'b1;
               pos      = 0;
            end else if (active) begin
               if (e_last) active = 1'b0;
               else        pos++;
            end
            if (valid[g] && e_rdy) load_cyc = 1'b1;
            exp_rdy = e_rdy;
         end
      end
   end

   task automatic send(input int l, input logic [7:0] b);
      bit r;
      bit done;
      done     = 1'b0;
      valid[l] = 1'b1;
      data[l]  = b;
      for (int n = 0; n < 2000 && !done; n++) begin
         @(negedge clk);
         r = ready[l];
         @(posedge clk);
         #1;
         if (r) done = 1'b1;
      end
      if (!done) chk(l, "send_timeout", 0, 1);
      valid[l] = 1'b0;
      data[l]  = 8'($urandom);
   endtask

   task automatic wait_frame(input int l);
      repeat (2 + 8 * bc_of(l)) @(posedge clk);
      #1;
   endtask

   task automatic idle_toggle(input int l, input int n);
      valid[l] = 1'b0;
      repeat (n) begin
         data[l] = 8'($urandom);
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int l = 0; l < 2; l++) begin
         valid[l] = 1'b0;
         data[l]  = 8'h00;
         abort[l] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      for (int l = 0; l < 2; l++) begin
         idle_toggle(l, 10);

         send(l, 8'hA5);
         wait_frame(l);
         send(l, 8'h81);
         wait_frame(l);

         send(l, 8'h0F);
         send(l, 8'hF0);
         wait_frame(l);

         send(l, 8'h3C);
         repeat (1 + 3 * bc_of(l)) @(posedge clk);
         #1;
         abort[l] = 1'b1;
         #1;
         chk(l, "abort_mode", mode[l], 0);
         chk(l, "abort_ready", ready[l], 0);
         @(posedge clk);
         #1;
         abort[l] = 1'b0;
         #1;
         chk(l, "ready_after_abort", ready[l], 1);
         send(l, 8'h55);
         wait_frame(l);

         send(l, 8'hC3);
         repeat (1 + 5 * bc_of(l)) @(posedge clk);
         #3;
         rst = 1'b1;
         #1;
         chk(l, "async_rst_mode",   mode[l], 0);
         chk(l, "async_rst_ready",  ready[l], 1);
         chk(l, "async_rst_bvalid", bv[l], 0);
         chk(l, "async_rst_index",  idx[l], 0);
         chk(l, "async_rst_last",   last[l], 0);
         chk(l, "async_rst_pdata",  par[l], 0);
         @(posedge clk);
         #1;
         rst = 1'b0;
         send(l, 8'hFF);
         wait_frame(l);

         for (int c = 0; c < 300; c++) begin
            valid[l] = ($urandom_range(0, 2) != 0);
            data[l]  = 8'($urandom);
            abort[l] = ($urandom_range(0, 39) == 0);
            @(posedge clk);
            #1;
         end
         valid[l] = 1'b0;
         abort[l] = 1'b0;
         wait_frame(l);
         idle_toggle(l, 10);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
